// File: rtl/armleocpu_decode_pkg.sv
// Shared constants and types for the decode stage: fetch/execute command
// encodings, fetched-word types, RISC-V opcodes and decode FSM states.
package armleocpu_decode_pkg;

    localparam int E2F_CMD_WIDTH  = 2;
    localparam int F2E_TYPE_WIDTH = 2;

    localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_NONE         = 2'd0;
    localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_ABORT        = 2'd1;
    localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_START_BRANCH = 2'd2;
    localparam logic [E2F_CMD_WIDTH-1:0] E2F_CMD_FLUSH        = 2'd3;

    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = 2'd0;
    localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = 2'd1;

    localparam logic [6:0] RV_OPCODE_SYSTEM   = 7'b1110011;
    localparam logic [6:0] RV_OPCODE_MISC_MEM = 7'b0001111;

    typedef enum logic [1:0] {
        DECODE_STATE_RUN       = 2'd0,
        DECODE_STATE_STALLED   = 2'd1,
        DECODE_STATE_SERIALIZE = 2'd2
    } decode_state_t;

    typedef struct packed {
        logic [F2E_TYPE_WIDTH-1:0] ftype;
        logic [31:0]               instr;
        logic [31:0]               pc;
    } f2e_entry_t;

    // A word must drain the pipeline before fetch continues if it is a
    // SYSTEM/MISC-MEM instruction or not an instruction at all.
    function automatic logic is_serializing(input logic [F2E_TYPE_WIDTH-1:0] ftype,
                                            input logic [6:0]                opcode);
        return (ftype != F2E_TYPE_INSTR) ||
               (opcode == RV_OPCODE_SYSTEM) ||
               (opcode == RV_OPCODE_MISC_MEM);
    endfunction

endpackage

// File: rtl/armleocpu_decode_buffer.sv
// Two-entry shift FIFO between fetch and execute; entry 0 is always the head,
// so the head fields come straight from flops.
module armleocpu_decode_buffer
    import armleocpu_decode_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       enq,
    input  logic       deq,
    input  f2e_entry_t din,
    output logic [1:0] count,
    output logic       head_valid,
    output f2e_entry_t head
);

    logic [1:0] cnt;
    f2e_entry_t mem0;
    f2e_entry_t mem1;
    logic       deq_eff;
    logic       enq_eff;
    logic       wr_slot0;

    assign deq_eff  = deq && (cnt != 2'd0);
    assign enq_eff  = enq && ((cnt != 2'd2) || deq_eff);
    assign wr_slot0 = enq_eff && ((cnt == 2'd0) || ((cnt == 2'd1) && deq_eff));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt + {1'b0, enq_eff} - {1'b0, deq_eff};
        end
    end

    // NOTE: payload storage has no reset; cnt alone qualifies its contents,
    // so resetting the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_slot0) begin
            mem0 <= din;
        end else if (deq_eff) begin
            mem0 <= mem1;
        end
        if (enq_eff && !wr_slot0) begin
            mem1 <= din;
        end
    end

    assign count      = cnt;
    assign head_valid = (cnt != 2'd0);
    assign head       = mem0;

endmodule

// File: rtl/armleocpu_decode.sv
// Decode stage: buffers fetched words for execute, pre-decodes register fields
// and steers fetch (abort on overflow/serializing words, resume, forward).
module armleocpu_decode
    import armleocpu_decode_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_2000
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      f2d_valid,
    input  logic [F2E_TYPE_WIDTH-1:0] f2d_type,
    input  logic [31:0]               f2d_instr,
    input  logic [31:0]               f2d_pc,

    output logic                      d2f_ready,
    output logic [E2F_CMD_WIDTH-1:0]  d2f_cmd,
    output logic [31:0]               d2f_branchtarget,

    output logic                      d2e_valid,
    input  logic                      d2e_ready,
    output logic [F2E_TYPE_WIDTH-1:0] d2e_type,
    output logic [31:0]               d2e_instr,
    output logic [31:0]               d2e_pc,
    output logic [4:0]                d2e_rd,
    output logic [4:0]                d2e_rs1,
    output logic [4:0]                d2e_rs2,
    output logic                      d2e_serialize,

    input  logic                      e2d_ready,
    input  logic [E2F_CMD_WIDTH-1:0]  e2d_cmd,
    input  logic [31:0]               e2d_branchtarget
);

    decode_state_t state;
    logic [31:0]   resume_pc;
    logic [1:0]    cnt;
    logic [1:0]    cnt_next;
    f2e_entry_t    head;
    f2e_entry_t    incoming;
    logic          e_cmd_active;
    logic          f2d_serializing;
    logic          enq;
    logic          deq;
    logic          fetch_stop;
    logic          resume;

    assign e_cmd_active    = e2d_ready && (e2d_cmd != E2F_CMD_NONE);
    assign f2d_serializing = is_serializing(f2d_type, f2d_instr[6:0]);

    // Words arriving outside RUN, or alongside an execute command, are dropped.
    assign enq        = f2d_valid && (state == DECODE_STATE_RUN) && !e_cmd_active;
    assign deq        = d2e_valid && d2e_ready;
    assign cnt_next   = cnt + {1'b0, enq} - {1'b0, deq};
    assign fetch_stop = enq && ((cnt_next == 2'd2) || f2d_serializing);
    assign resume     = (state == DECODE_STATE_STALLED) && (cnt != 2'd2) && !e_cmd_active;

    assign incoming = '{ftype: f2d_type, instr: f2d_instr, pc: f2d_pc};

    armleocpu_decode_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (e_cmd_active),
        .enq        (enq),
        .deq        (deq),
        .din        (incoming),
        .count      (cnt),
        .head_valid (d2e_valid),
        .head       (head)
    );

    // NOTE: every output gets a default before the priority chain so no
    // path through always_comb leaves a latch behind.
    always_comb begin
        d2f_ready        = 1'b0;
        d2f_cmd          = E2F_CMD_NONE;
        d2f_branchtarget = 32'h0;
        if (e_cmd_active) begin
            d2f_ready        = 1'b1;
            d2f_cmd          = e2d_cmd;
            d2f_branchtarget = e2d_branchtarget;
        end else if (fetch_stop) begin
            d2f_ready = 1'b1;
            d2f_cmd   = E2F_CMD_ABORT;
        end else if (resume) begin
            d2f_ready        = 1'b1;
            d2f_cmd          = E2F_CMD_START_BRANCH;
            d2f_branchtarget = resume_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DECODE_STATE_RUN;
            resume_pc <= RESET_VECTOR;
        end else begin
            if (e_cmd_active) begin
                state <= (e2d_cmd == E2F_CMD_START_BRANCH) ? DECODE_STATE_RUN
                                                           : DECODE_STATE_SERIALIZE;
            end else if (fetch_stop) begin
                state <= f2d_serializing ? DECODE_STATE_SERIALIZE : DECODE_STATE_STALLED;
            end else if (resume) begin
                state <= DECODE_STATE_RUN;
            end
            if (enq) begin
                resume_pc <= f2d_pc + 32'd4;
            end
        end
    end

    assign d2e_type      = head.ftype;
    assign d2e_instr     = head.instr;
    assign d2e_pc        = head.pc;
    assign d2e_rd        = head.instr[11:7];
    assign d2e_rs1       = head.instr[19:15];
    assign d2e_rs2       = head.instr[24:20];
    assign d2e_serialize = is_serializing(head.ftype, head.instr[6:0]);

`ifdef FORMAL_RULES
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(enq && (cnt == 2'd2) && !deq));
            assert (!(f2d_valid && (state != DECODE_STATE_RUN) && !e_cmd_active));
        end
    end
`endif

endmodule
